// File: rtl/reg_write_log_packer.sv
// Register-write commit log packer: buffers {reg_id, data} events in a FIFO and
// streams each one out as ITEM_WORDS dpi words over a valid/ready interface.
module reg_write_log_packer #(
  parameter int DPI_WORD_W = 32,
  parameter int ITEM_WORDS = 3,
  parameter int DEPTH      = 8,
  parameter int HART_ID    = 0,
  localparam int IDX_W     = (ITEM_WORDS > 1) ? $clog2(ITEM_WORDS) : 1,
  localparam int PW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [31:0]           wr_reg_id_i,
  input  logic [63:0]           wr_data_i,
  output logic [DPI_WORD_W-1:0] word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [IDX_W-1:0]      word_idx_o,
  output logic                  word_last_o,
  output logic [PW-1:0]         pending_o,
  output logic                  overflow_o,
  output logic [31:0]           hart_id_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int ITEM_W = 96;
  localparam int PAD_W  = (ITEM_WORDS * DPI_WORD_W > ITEM_W) ? ITEM_WORDS * DPI_WORD_W : ITEM_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [ITEM_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PW-1:0]     count;
  logic [PW-1:0]     count_next;
  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              ovf;

  logic              full;
  logic              empty;
  logic              sending;
  logic              handshake;
  logic              at_last;
  logic              push;
  logic              pop;
  logic [PAD_W-1:0]  head_pad;
  logic [DPI_WORD_W-1:0] head_word;

  always_comb begin
    full       = (count == PW'(DEPTH));
    empty      = (count == '0);
    sending    = (state == SEND);
    handshake  = sending & word_ready_i;
    at_last    = (idx == IDX_W'(ITEM_WORDS - 1));
    pop        = handshake & at_last;
    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
    push       = wr_valid_i & ~full;
    count_next = count + PW'(push) - PW'(pop);
    head_pad   = PAD_W'(mem[rd_ptr]);
    head_word  = head_pad[int'(idx) * DPI_WORD_W +: DPI_WORD_W];
  end

  always_ff @(posedge clk_i) begin
    if (push && rst_ni && !flush_i) begin
      mem[wr_ptr] <= {wr_reg_id_i, wr_data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      idx    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (wr_valid_i && full) begin
        ovf <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        default: begin
          if (handshake) begin
            if (at_last) begin
              // A push landing with the final pop keeps the stream gap-free.
              idx <= '0;
              if (count_next == '0) begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    word_valid_o = sending;
    word_o       = sending ? head_word : '0;
    word_idx_o   = idx;
    word_last_o  = sending & at_last;
    pending_o    = count;
    overflow_o   = ovf;
    hart_id_o    = 32'(HART_ID);
  end

endmodule

// File: tb/tb_reg_write_log_packer.sv
// Scoreboard bench for reg_write_log_packer: directed scenarios plus random
// traffic, with a word-queue reference model and a decoupled output monitor.
module tb_reg_write_log_packer;
  localparam int W    = 32;
  localparam int IW   = 3;
  localparam int D    = 8;
  localparam int HART = 5;

  logic        clk = 1'b0;
  logic        rst_n, flush, wr_valid, word_ready;
  logic [31:0] wr_reg_id;
  logic [63:0] wr_data;
  logic [31:0] word;
  logic        word_valid, word_last, overflow;
  logic [1:0]  word_idx;
  logic [3:0]  pending;
  logic [31:0] hart_id;

  always #5 clk = ~clk;

  reg_write_log_packer #(
    .DPI_WORD_W(W),
    .ITEM_WORDS(IW),
    .DEPTH(D),
    .HART_ID(HART)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .flush_i(flush),
    .wr_valid_i(wr_valid),
    .wr_reg_id_i(wr_reg_id),
    .wr_data_i(wr_data),
    .word_o(word),
    .word_valid_o(word_valid),
    .word_ready_i(word_ready),
    .word_idx_o(word_idx),
    .word_last_o(word_last),
    .pending_o(pending),
    .overflow_o(overflow),
    .hart_id_o(hart_id)
  );

  typedef struct {
    logic [31:0] w;
    int unsigned idx;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  bit   ovf_exp     = 1'b0;
  bit   popped_last = 1'b0;
  bit   active      = 1'b0;
  int   checks      = 0;
  int   failures    = 0;
  int   hs_count    = 0;

  function automatic int unsigned items();
    return (exp_q.size() + IW - 1) / IW;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pending/overflow against the model, and every accepted word popped in order.
  always @(negedge clk) begin
    if (active) begin
      popped_last = 1'b0;
      chk("pending", 96'(pending), 96'(items()));
      chk("overflow", 96'(overflow), 96'(ovf_exp));
      if (word_valid && word_ready && rst_n && !flush) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 96'(word_valid), 96'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          hs_count++;
          chk("word", 96'(word), 96'(e.w));
          chk("word_idx", 96'(word_idx), 96'(e.idx));
          chk("word_last", 96'(word_last), 96'(e.last));
          if (e.last) popped_last = 1'b1;
        end
      end
    end
  end

  // Reference model: a full item still counts as pending until its last word goes,
  // and an item leaving at this edge does not make room for one arriving.
  always @(negedge clk) begin
    #1;
    if (!rst_n || flush) begin
      exp_q.delete();
      ovf_exp = 1'b0;
    end else if (wr_valid) begin
      if (items() + popped_last < D) begin
        logic [95:0] it;
        it = {wr_reg_id, wr_data};
        for (int k = 0; k < IW; k++)
          exp_q.push_back('{w: it[32*k +: 32], idx: k, last: (k == IW - 1)});
      end else begin
        ovf_exp = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic [63:0] d);
    wr_valid  = 1'b1;
    wr_reg_id = r;
    wr_data   = d;
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic push_rand();
    push($urandom(), {$urandom(), $urandom()});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 96'(word_valid), 96'(0));
    chk({tag, "_word"}, 96'(word), 96'(0));
    chk({tag, "_idx"}, 96'(word_idx), 96'(0));
    chk({tag, "_last"}, 96'(word_last), 96'(0));
    chk({tag, "_pending"}, 96'(pending), 96'(0));
    chk({tag, "_overflow"}, 96'(overflow), 96'(0));
    chk({tag, "_hart_id"}, 96'(hart_id), 96'(HART));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || word_valid); i++) tick();
    chk({tag, "_drain_left"}, 96'(exp_q.size()), 96'(0));
    chk({tag, "_drain_valid"}, 96'(word_valid), 96'(0));
  endtask

  task automatic chk_conc();
    chk("conc_valid", 96'(word_valid), 96'(1));
    chk("conc_pending_le1", 96'(pending <= 4'd1), 96'(1));
  endtask

  initial begin
    int hs0;
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; word_ready = 1'b0;
    wr_reg_id = '0; wr_data = '0;
    tick();
    active = 1'b1;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Single event with ready held high.
    word_ready = 1'b1;
    push(32'h0000_0005, 64'h1122_3344_5566_7788);
    chk("single_pending_1", 96'(pending), 96'(1));
    chk("single_not_yet_valid", 96'(word_valid), 96'(0));
    tick();
    chk("single_w0", 96'(word), 96'(32'h5566_7788));
    chk("single_w0_last", 96'(word_last), 96'(0));
    tick();
    chk("single_w1", 96'(word), 96'(32'h1122_3344));
    tick();
    chk("single_w2", 96'(word), 96'(32'h0000_0005));
    chk("single_w2_last", 96'(word_last), 96'(1));
    tick();
    chk("single_end_valid", 96'(word_valid), 96'(0));
    chk("single_pending_0", 96'(pending), 96'(0));

    // Backpressure: first word held stable for four stalled cycles.
    word_ready = 1'b0;
    push(32'h0000_0005, 64'h1122_3344_5566_7788);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 96'(word_valid), 96'(1));
      chk("bp_word", 96'(word), 96'(32'h5566_7788));
      chk("bp_idx", 96'(word_idx), 96'(0));
      tick();
    end
    word_ready = 1'b1;
    wait_drain("bp", 10);

    // Fill: nine pushes into an eight-deep FIFO with no drain.
    word_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) push_rand();
    chk("fill_pending", 96'(pending), 96'(D));
    chk("fill_overflow", 96'(overflow), 96'(1));
    hs0 = hs_count;
    word_ready = 1'b1;
    wait_drain("fill", 40);
    chk("fill_words", 96'(hs_count - hs0), 96'(D * IW));
    chk("fill_overflow_sticky", 96'(overflow), 96'(1));

    // Flush clears the sticky overflow; then steady one-item-per-three-cycles traffic.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears_overflow", 96'(overflow), 96'(0));
    word_ready = 1'b1;
    push_rand();
    tick();
    for (int n = 0; n < 20; n++) begin
      chk_conc();
      wr_valid  = ((n % 3) == 2);
      wr_reg_id = $urandom();
      wr_data   = {$urandom(), $urandom()};
      tick();
    end
    wr_valid = 1'b0;
    wait_drain("conc", 20);

    // Flush after word1 of the first of two queued items, with a push in the flush cycle.
    word_ready = 1'b0;
    push_rand();
    push_rand();
    word_ready = 1'b1;
    tick();
    tick();
    chk("fm_idx_before", 96'(word_idx), 96'(2));
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = {$urandom(), $urandom()};
    tick();
    flush = 1'b0;
    wr_valid = 1'b0;
    chk("fm_valid", 96'(word_valid), 96'(0));
    chk("fm_pending", 96'(pending), 96'(0));
    chk("fm_overflow", 96'(overflow), 96'(0));
    chk("fm_idx", 96'(word_idx), 96'(0));
    push(32'hABCD_0001, 64'h0BAD_F00D_CAFE_0123);
    tick();
    chk("fm_restart_idx", 96'(word_idx), 96'(0));
    chk("fm_restart_word", 96'(word), 96'(32'hCAFE_0123));
    wait_drain("fm", 10);

    // Reset with five items queued and overflow set.
    word_ready = 1'b0;
    for (int i = 0; i < D + 1; i++) push_rand();
    word_ready = 1'b1;
    for (int i = 0; i < 3 * IW; i++) tick();
    word_ready = 1'b0;
    chk("mr_pending", 96'(pending), 96'(5));
    chk("mr_overflow", 96'(overflow), 96'(1));
    rst_n = 1'b0;
    tick();
    chk_reset("midreset");
    rst_n = 1'b1;
    tick();

    // Random traffic in bursty-ready blocks with occasional flushes.
    for (int blk = 0; blk < 8; blk++) begin
      bit fast;
      fast = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < 50; c++) begin
        wr_valid   = ($urandom_range(0, 1) == 1);
        wr_reg_id  = $urandom();
        wr_data    = {$urandom(), $urandom()};
        word_ready = fast ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
        flush      = ($urandom_range(0, 63) == 0);
        tick();
      end
    end
    wr_valid = 1'b0;
    flush = 1'b0;
    word_ready = 1'b1;
    wait_drain("rand", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_log_packer.md
Name: reg_write_log_packer

Overview:
- RTL-side producer of register-write commit logs for the cosim comparator; counterpart of the C-side log getters, which consume dpi_word_t arrays.
- Captures DUT register-write events for one processor into an item FIFO.
- Serializes each item into ITEM_WORDS dpi words over a valid/ready stream, drained by the DPI export glue.
- Reports the pending item count, used as inserted_elements.

Parameters:
- DPI_WORD_W, 32: width of one dpi word.
- ITEM_WORDS, 3: dpi words per item; must equal LOG_REG_WRITE_ITEM_DPI_WORDS.
- DEPTH, 8: item FIFO depth; power of two, ≥2.
- HART_ID, 0: processor index, reported on hart_id_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  synchronous clear of FIFO, serializer and overflow.
- wr_valid_i  in  1  DUT register-write event this cycle.
- wr_reg_id_i  in  32  register key (file type bits plus index).
- wr_data_i  in  64  written value.
- word_o  out  DPI_WORD_W  current serialized word.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o.
- word_idx_o  out  $clog2(ITEM_WORDS)  index of word_o within its item.
- word_last_o  out  1  word_o is the final word of its item.
- pending_o  out  $clog2(DEPTH)+1  items stored, including the one being serialized.
- overflow_o  out  1  sticky; at least one event was dropped.
- hart_id_o  out  32  constant HART_ID.

Behaviour:
- Reset (rst_ni=0 at clk edge):
  - FIFO empty; serializer IDLE.
  - word_valid_o=0, word_o=0, word_idx_o=0, word_last_o=0, pending_o=0, overflow_o=0.
- Item layout: item = {wr_reg_id_i, wr_data_i}, 96 bits; word k = item[32k +: 32].
  - word0 = data[31:0], word1 = data[63:32], word2 = reg_id.
  - If ITEM_WORDS*DPI_WORD_W exceeds 96, the upper bits are zero.
- Push:
  - When wr_valid_i=1 and pending_o<DEPTH at the edge, the item is written; pending_o increments next cycle.
  - When wr_valid_i=1 and pending_o==DEPTH, the event is dropped and overflow_o is set next cycle.
  - A pop in the same cycle does not make room: no full bypass.
- Serializer FSM:
  - IDLE: if FIFO non-empty, go to SEND with idx=0. word_valid_o rises one cycle after the first push into an empty FIFO.
  - SEND: word_valid_o=1; word_o/word_idx_o come from the head item and idx. word_last_o = (idx==ITEM_WORDS-1).
    - On word_valid_o & word_ready_i with idx<last: idx+1.
    - On the handshake at idx==last: pop the head and decrement pending_o.
      - If the FIFO is still non-empty, stay in SEND with idx=0: back-to-back items, no bubble.
      - Otherwise go to IDLE.
  - Word outputs are registered, or combinational from registered state only. They stay stable while word_valid_o=1 and word_ready_i=0.
- Simultaneous push and final-word pop: pending_o is unchanged.
- Pointers wrap modulo DEPTH; full/empty are derived from pending_o.
- flush_i=1: same effect as reset on all outputs except hart_id_o. It takes priority over push and pop that cycle, so the pushed event is discarded and does not set overflow.
- Reset or flush mid-item: the partial item is abandoned and idx returns to 0. The consumer must treat a word_idx_o return to 0 without a prior word_last_o handshake as an abort.

Test Plan:
- Single event: reg_id=0x0000_0005, data=0x1122_3344_5566_7788, ready held 1.
  - Words 0x5566_7788, 0x1122_3344, 0x0000_0005 on 3 consecutive cycles, starting 1 cycle after push.
  - word_last_o only on the third; pending_o goes 1 then 0.
- Backpressure: ready=0 for 4 cycles then 1.
  - word_o=0x5566_7788 and idx=0 are held stable for all 4 cycles; then 3 accepted words.
- Fill: DEPTH=8 with ready=0, 9 pushes.
  - pending_o=8, overflow_o=1.
  - Draining returns exactly the first 8 items in order: 24 words.
- Concurrent: steady push of one item per 3 cycles with ready=1.
  - pending_o stays ≤1; continuous word_valid_o with no idle cycles between items.
- Flush mid-item: flush after word1 is accepted, with 2 items queued.
  - Next cycle: word_valid_o=0, pending_o=0, overflow_o=0.
  - A subsequent push restarts at idx=0.
- Reset mid-operation: rst_ni=0 for 1 cycle with 5 items queued and overflow_o=1.
  - All outputs at reset values next cycle; hart_id_o=HART_ID.
